s_axil_cfg_regs: RTL and testbench
==================================

Name: s_axil_cfg_regs

Overview:
AXI4-Lite slave register file that programs the counter write master. It sits directly upstream of that master and drives its configuration array (ENABLED, ADDR_W_0, ADDR_W_1, LENGTH, INCR_STEP, STATUS) from host writes. STATUS is read-only and is sourced from the master. Independent write and read channel FSMs are provided, one outstanding transaction each.

Parameters:
DATA_WIDTH, 32, register and AXI data width (multiple of 8)
ADDR_WIDTH, 32, AXI address width
REG_COUNT, 6, number of registers; index 5 is STATUS (RO)

Ports:
clk  input  1  clock
areset  input  1  synchronous active-low reset, sampled on posedge clk
awaddr_i  input  ADDR_WIDTH  write address
awvalid_i / awready_o  in/out  1  AW handshake
wdata_i  input  DATA_WIDTH  write data
wstrb_i  input  DATA_WIDTH/8  byte strobes
wvalid_i / wready_o  in/out  1  W handshake
bresp_o  output  2  write response
bvalid_o / bready_i  out/in  1  B handshake
araddr_i  input  ADDR_WIDTH  read address
arvalid_i / arready_o  in/out  1  AR handshake
rdata_o  output  DATA_WIDTH  read data
rresp_o  output  2  read response
rvalid_o / rready_i  out/in  1  R handshake
regs_o  output  DATA_WIDTH x [0:REG_COUNT-1]  configuration array to the master
status_i  input  DATA_WIDTH  live status from the master
done_i  input  1  single-cycle pulse from the master marking a completed run

Behaviour:
- Address map: byte offset = index*4, index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored. 0x00 ENABLED, 0x04 ADDR_W_0, 0x08 ADDR_W_1, 0x0C LENGTH, 0x10 INCR_STEP, 0x14 STATUS.
- Reset (areset=0 at posedge): all regs_o=0; awready_o=wready_o=arready_o=1; bvalid_o=rvalid_o=0; bresp_o=rresp_o=0; rdata_o=0; both FSMs return to IDLE. A reset mid-transaction drops the transaction with no response.
- regs_o[5] = status_i, combinational passthrough. All other entries are flops.
- Write FSM states:
  - W_IDLE: awready_o=1 until AW is captured; wready_o=1 until W is captured. AW and W are captured independently, in either order or in the same cycle. Each ready drops the cycle after its own capture.
  - W_IDLE -> W_EXEC on the cycle both have been captured.
  - W_EXEC (1 cycle): commit the write. For each byte b with wstrb[b]=1, reg[idx] byte b = wdata byte b. Then bvalid_o=1 and bresp_o is set.
  - W_RESP: hold bvalid_o and bresp_o stable until bready_i. On handshake: bvalid_o=0, awready_o=wready_o=1, return to W_IDLE.
- Write responses: idx<5 -> OKAY (2'b00). idx=5 (STATUS) or idx>=REG_COUNT -> SLVERR (2'b10) with no register change. wstrb=0 -> OKAY, no change.
- Minimum write latency: AW and W in the same cycle -> bvalid_o asserted 2 cycles later.
- Read FSM states:
  - R_IDLE: arready_o=1. On arvalid_i, sample the register contents that cycle into rdata_o. Set rvalid_o=1 and arready_o=0 the next cycle.
  - R_DATA: hold rdata_o, rresp_o and rvalid_o until rready_i, then return to R_IDLE with arready_o=1.
- Read responses: idx>=REG_COUNT -> rdata_o=0, rresp_o=SLVERR. Otherwise OKAY.
- Read/write collision: a read captured in the same cycle as a W_EXEC commit to the same register returns the pre-write value.
- Read and write channels run fully concurrently.
- done_i is ignored unless the optional feature is enabled.

Optional Feature:
Macro AXIL_CFG_AUTOCLR_EN.
- Defined: a done_i pulse clears bit 0 of ENABLED the following cycle. If a W_EXEC write to ENABLED occurs in the same cycle as done_i, the host write wins.
- Undefined: done_i has no effect; ENABLED changes only by host write.

Test Plan:
- Reset, then read 0x00..0x10 -> rdata 0, rresp OKAY each; read 0x14 with status_i=0x3 -> rdata 0x3.
- AW 0x0C and W 0x0000_0010 (wstrb 0xF) in the same cycle -> bvalid 2 cycles later, bresp OKAY, regs_o[3]=0x10; readback 0x10.
- W 0xAABBCCDD presented 3 cycles before AW 0x04; then wstrb 0x3 write of 0x11223344 -> regs_o[1]=0xAABB3344.
- Write 0x14 and write 0x40 -> bresp SLVERR, no reg change; read 0x40 -> rdata 0, rresp SLVERR.
- Hold bready=0 for 5 cycles and rready=0 for 4 cycles -> bvalid/bresp and rvalid/rdata stable, no new AW/AR accepted; release -> ready lines return to 1.
- With AXIL_CFG_AUTOCLR_EN: ENABLED=1, pulse done_i -> ENABLED=0 next cycle; done_i coincident with W_EXEC writing 1 -> ENABLED=1. Without the macro -> ENABLED stays 1.

Source files
------------

// File: rtl/s_axil_cfg_regs.sv
// s_axil_cfg_regs: AXI4-Lite register file that programs the counter write master.
// Map (index = addr[ADDR_WIDTH-1:2]): 0x00 ENABLED, 0x04 ADDR_W_0, 0x08 ADDR_W_1,
// 0x0C LENGTH, 0x10 INCR_STEP, 0x14 STATUS (read-only, live from status_i).
// Optional: define AXIL_CFG_AUTOCLR_EN to let a done_i pulse clear ENABLED[0].
module s_axil_cfg_regs #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned REG_COUNT  = 6
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic [ADDR_WIDTH-1:0]   awaddr_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    output logic [1:0]              bresp_o,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    input  logic [ADDR_WIDTH-1:0]   araddr_i,
    input  logic                    arvalid_i,
    output logic                    arready_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [1:0]              rresp_o,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    output logic [DATA_WIDTH-1:0]   regs_o [0:REG_COUNT-1],
    input  logic [DATA_WIDTH-1:0]   status_i,
    input  logic                    done_i
);
    localparam int unsigned StrbW     = DATA_WIDTH / 8;
    localparam int unsigned IdxW      = ADDR_WIDTH - 2;
    // STATUS is the last entry; everything below it is host-writable storage.
    localparam int unsigned StatusIdx = REG_COUNT - 1;
    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;

    typedef enum logic [1:0] {StWIdle, StWExec, StWResp} w_state_e;
    typedef enum logic {StRIdle, StRData} r_state_e;

    w_state_e              w_state_q, w_state_d;
    r_state_e              r_state_q, r_state_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [IdxW-1:0]       wr_idx_q, wr_idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [StrbW-1:0]      wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] regs_q [StatusIdx];
    logic [DATA_WIDTH-1:0] regs_d [StatusIdx];

    logic                  aw_hs, w_hs, ar_hs, wr_ok;
    logic [IdxW-1:0]       rd_idx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [1:0]            rd_resp;

    assign awready_o = (w_state_q == StWIdle) && !aw_done_q;
    assign wready_o  = (w_state_q == StWIdle) && !w_done_q;
    assign arready_o = (r_state_q == StRIdle);
    assign aw_hs     = awvalid_i && awready_o;
    assign w_hs      = wvalid_i && wready_o;
    assign ar_hs     = arvalid_i && arready_o;
    assign wr_ok     = wr_idx_q < IdxW'(StatusIdx);
    assign rd_idx    = araddr_i[ADDR_WIDTH-1:2];

    assign bvalid_o = bvalid_q;
    assign bresp_o  = bresp_q;
    assign rvalid_o = rvalid_q;
    assign rresp_o  = rresp_q;
    assign rdata_o  = rdata_q;

    // Byte-offset bits and (when auto-clear is off) done_i carry no information here.
    logic unused_inputs;
`ifdef AXIL_CFG_AUTOCLR_EN
    assign unused_inputs = ^{awaddr_i[1:0], araddr_i[1:0]};
`else
    assign unused_inputs = ^{awaddr_i[1:0], araddr_i[1:0], done_i};
`endif

    // Configuration array towards the master; STATUS is a straight passthrough.
    always_comb begin
        for (int i = 0; i < int'(StatusIdx); i++) begin
            regs_o[i] = regs_q[i];
        end
        regs_o[StatusIdx] = status_i;
    end

    // Read mux: out-of-range indices read as zero with SLVERR.
    always_comb begin
        rd_data = '0;
        rd_resp = RespSlvErr;
        for (int i = 0; i < int'(StatusIdx); i++) begin
            if (rd_idx == IdxW'(i)) begin
                rd_data = regs_q[i];
                rd_resp = RespOkay;
            end
        end
        if (rd_idx == IdxW'(StatusIdx)) begin
            rd_data = status_i;
            rd_resp = RespOkay;
        end
    end

    // Register next state: auto-clear first so a coincident host write overrides it.
    always_comb begin
        regs_d = regs_q;
`ifdef AXIL_CFG_AUTOCLR_EN
        if (done_i) begin
            regs_d[0][0] = 1'b0;
        end
`endif
        if (w_state_q == StWExec) begin
            for (int i = 0; i < int'(StatusIdx); i++) begin
                if (wr_idx_q == IdxW'(i)) begin
                    for (int b = 0; b < int'(StrbW); b++) begin
                        if (wstrb_q[b]) begin
                            regs_d[i][b*8 +: 8] = wdata_q[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Write channel FSM: capture AW and W independently, commit, then respond.
    always_comb begin
        w_state_d = w_state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        wr_idx_d  = wr_idx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        unique case (w_state_q)
            StWIdle: begin
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                    wr_idx_d  = awaddr_i[ADDR_WIDTH-1:2];
                end
                if (w_hs) begin
                    w_done_d = 1'b1;
                    wdata_d  = wdata_i;
                    wstrb_d  = wstrb_i;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    w_state_d = StWExec;
                end
            end
            StWExec: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                bvalid_d  = 1'b1;
                bresp_d   = wr_ok ? RespOkay : RespSlvErr;
                w_state_d = StWResp;
            end
            StWResp: begin
                if (bready_i) begin
                    bvalid_d  = 1'b0;
                    w_state_d = StWIdle;
                end
            end
            default: w_state_d = StWIdle;
        endcase
    end

    // Read channel FSM: sample on AR, hold the response until accepted.
    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            StRIdle: begin
                if (ar_hs) begin
                    rdata_d   = rd_data;
                    rresp_d   = rd_resp;
                    rvalid_d  = 1'b1;
                    r_state_d = StRData;
                end
            end
            StRData: begin
                if (rready_i) begin
                    rvalid_d  = 1'b0;
                    r_state_d = StRIdle;
                end
            end
            default: r_state_d = StRIdle;
        endcase
    end

    // State registers with synchronous active-low reset; reset drops any open transaction.
    always_ff @(posedge clk) begin
        if (!areset) begin
            w_state_q <= StWIdle;
            r_state_q <= StRIdle;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wr_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RespOkay;
            rvalid_q  <= 1'b0;
            rresp_q   <= RespOkay;
            rdata_q   <= '0;
            for (int i = 0; i < int'(StatusIdx); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            wr_idx_q  <= wr_idx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            regs_q    <= regs_d;
        end
    end

endmodule

// File: tb/tb_s_axil_cfg_regs.sv
// tb_s_axil_cfg_regs: directed + randomized bench for s_axil_cfg_regs against a
// register-array reference model. Honours AXIL_CFG_AUTOCLR_EN like the design.
module tb_s_axil_cfg_regs;
    logic        clk = 1'b0;
    logic        areset = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] regs [0:5];
    logic [31:0] status = '0;
    logic        done = 1'b0;

    int checks = 0;
    int failures = 0;

    // Reference model: five writable words; STATUS comes from the status stimulus.
    logic [31:0] model [0:4];

    s_axil_cfg_regs #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .REG_COUNT (6)
    ) dut (
        .clk      (clk),
        .areset   (areset),
        .awaddr_i (awaddr),
        .awvalid_i(awvalid),
        .awready_o(awready),
        .wdata_i  (wdata),
        .wstrb_i  (wstrb),
        .wvalid_i (wvalid),
        .wready_o (wready),
        .bresp_o  (bresp),
        .bvalid_o (bvalid),
        .bready_i (bready),
        .araddr_i (araddr),
        .arvalid_i(arvalid),
        .arready_o(arready),
        .rdata_o  (rdata),
        .rresp_o  (rresp),
        .rvalid_o (rvalid),
        .rready_i (rready),
        .regs_o   (regs),
        .status_i (status),
        .done_i   (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r = (r & ~(32'hFF << (8 * b))) | (d & (32'hFF << (8 * b)));
        end
        return r;
    endfunction

    // Applies a host write to the model and returns the response it should get.
    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] d,
                                               input logic [3:0] s);
        int unsigned idx = addr >> 2;
        if (idx < 5) begin
            model[idx] = merge(model[idx], d, s);
            return 2'b00;
        end
        return 2'b10;
    endfunction

    function automatic logic [33:0] model_read(input logic [31:0] addr);
        int unsigned idx = addr >> 2;
        if (idx < 5) return {2'b00, model[idx]};
        if (idx == 5) return {2'b00, status};
        return {2'b10, 32'h0};
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < 5; i++) check_eq($sformatf("%s_reg%0d", tag, i), regs[i], model[i]);
        check_eq({tag, "_status_pass"}, regs[5], status);
    endtask

    // Called at a negedge; returns at a negedge with the channel idle again.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int b_hold, input logic [1:0] exp_resp);
        bit aw_sent = 0;
        bit w_sent = 0;
        bit aw_hs, w_hs;
        int t = 0;
        int lat;
        awaddr = addr;
        wdata  = data;
        wstrb  = strb;
        while (!(aw_sent && w_sent) && t < 40) begin
            if (aw_sent) check_eq("awready_low_after_capture", awready, 1'b0);
            if (w_sent) check_eq("wready_low_after_capture", wready, 1'b0);
            awvalid = !aw_sent && (t >= aw_dly);
            wvalid  = !w_sent && (t >= w_dly);
            aw_hs   = awvalid && awready;
            w_hs    = wvalid && wready;
            @(negedge clk);
            if (aw_hs) aw_sent = 1;
            if (w_hs) w_sent = 1;
            t++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check_eq("aw_w_accepted", {aw_sent, w_sent}, 2'b11);
        if (!(aw_sent && w_sent)) return;
        lat = 1;
        while (!bvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq("write_latency", lat, 2);
        check_eq("bresp", bresp, exp_resp);
        repeat (b_hold) begin
            @(negedge clk);
            check_eq("bvalid_hold", bvalid, 1'b1);
            check_eq("bresp_hold", bresp, exp_resp);
            check_eq("awready_during_resp", awready, 1'b0);
            check_eq("wready_during_resp", wready, 1'b0);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check_eq("bvalid_after_hs", bvalid, 1'b0);
        check_eq("awready_after_hs", awready, 1'b1);
        check_eq("wready_after_hs", wready, 1'b1);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int r_hold,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        araddr  = addr;
        check_eq("arready_idle", arready, 1'b1);
        arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        check_eq("rvalid_next", rvalid, 1'b1);
        check_eq("arready_busy", arready, 1'b0);
        check_eq("rdata", rdata, exp_data);
        check_eq("rresp", rresp, exp_resp);
        repeat (r_hold) begin
            @(negedge clk);
            check_eq("rvalid_hold", rvalid, 1'b1);
            check_eq("rdata_hold", rdata, exp_data);
            check_eq("rresp_hold", rresp, exp_resp);
            check_eq("arready_hold", arready, 1'b0);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check_eq("rvalid_after_hs", rvalid, 1'b0);
        check_eq("arready_after_hs", arready, 1'b1);
    endtask

    task automatic read_model(input logic [31:0] addr, input int r_hold);
        logic [33:0] e = model_read(addr);
        axi_read(addr, r_hold, e[31:0], e[33:32]);
    endtask

    task automatic write_model(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int aw_dly, input int w_dly,
                               input int b_hold);
        logic [1:0] r = model_write(addr, data, strb);
        axi_write(addr, data, strb, aw_dly, w_dly, b_hold, r);
    endtask

    initial begin
        logic [31:0] old;
        logic [1:0]  resp;
        for (int i = 0; i < 5; i++) model[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        areset = 1'b1;
        @(negedge clk);
        check_eq("rst_awready", awready, 1'b1);
        check_eq("rst_wready", wready, 1'b1);
        check_eq("rst_arready", arready, 1'b1);
        check_eq("rst_bvalid", bvalid, 1'b0);
        check_eq("rst_rvalid", rvalid, 1'b0);
        check_eq("rst_bresp", bresp, 2'b00);
        check_eq("rst_rresp", rresp, 2'b00);
        check_eq("rst_rdata", rdata, 32'h0);
        check_regs("rst");
        for (int i = 0; i < 5; i++) axi_read(32'(i * 4), 0, 32'h0, 2'b00);
        status = 32'h3;
        axi_read(32'h14, 0, 32'h3, 2'b00);

        // Same-cycle AW/W to LENGTH
        write_model(32'h0C, 32'h0000_0010, 4'hF, 0, 0, 0);
        check_eq("length_value", regs[3], 32'h10);
        read_model(32'h0C, 0);

        // W leads AW by three cycles, then a partial-strobe write
        write_model(32'h04, 32'hAABB_CCDD, 4'hF, 3, 0, 0);
        write_model(32'h04, 32'h1122_3344, 4'h3, 0, 0, 0);
        check_eq("partial_strobe", regs[1], 32'hAABB_3344);
        write_model(32'h08, 32'h5555_6666, 4'h0, 0, 2, 0);
        check_regs("strb_zero");

        // Error responses
        write_model(32'h14, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        write_model(32'h40, 32'hFFFF_FFFF, 4'hF, 1, 0, 0);
        check_regs("slverr_no_change");
        axi_read(32'h40, 0, 32'h0, 2'b10);

        // Back-pressure on B and R
        write_model(32'h10, 32'h0000_0004, 4'hF, 0, 0, 5);
        read_model(32'h10, 4);

        // Read captured on the same edge as the commit returns the old value
        old  = model[2];
        resp = model_write(32'h08, 32'hCAFE_F00D, 4'hF);
        fork
            axi_write(32'h08, 32'hCAFE_F00D, 4'hF, 0, 0, 0, resp);
            begin
                @(negedge clk);
                axi_read(32'h08, 0, old, 2'b00);
            end
        join
        check_regs("collision");

        // Auto-clear of ENABLED[0] by done_i
        write_model(32'h00, 32'h1, 4'hF, 0, 0, 0);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
`ifdef AXIL_CFG_AUTOCLR_EN
        model[0][0] = 1'b0;
`endif
        check_eq("done_effect", regs[0], model[0]);
        resp = model_write(32'h00, 32'h3, 4'hF);
        fork
            axi_write(32'h00, 32'h3, 4'hF, 0, 0, 0, resp);
            begin
                @(negedge clk);
                done = 1'b1;
                @(negedge clk);
                done = 1'b0;
            end
        join
        check_eq("host_wins_over_done", regs[0], 32'h3);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            int unsigned idx = $urandom_range(0, 9);
            logic [31:0] addr;
            if (idx == 9) idx = 16;
            addr   = idx * 4 + $urandom_range(0, 3);
            status = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                write_model(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                            $urandom_range(0, 3), $urandom_range(0, 3));
                check_regs("rand_wr");
            end else begin
                read_model(addr, $urandom_range(0, 3));
            end
        end

        // Reset during a write drops it without a response
        awaddr  = 32'h00;
        wdata   = 32'hFFFF_FFFF;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        areset  = 1'b0;
        @(negedge clk);
        areset  = 1'b1;
        for (int i = 0; i < 5; i++) model[i] = '0;
        repeat (2) @(negedge clk);
        check_eq("midrst_bvalid", bvalid, 1'b0);
        check_eq("midrst_awready", awready, 1'b1);
        check_eq("midrst_wready", wready, 1'b1);
        check_regs("midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
